// File: rtl/ode_pkg.sv
// Shared types, defaults and saturation helper for the forward-Euler oscillator engine.
package ode_pkg;

  localparam int W_DEF        = 18;
  localparam int FRAC_DEF     = 16;
  localparam int DT_SHIFT_DEF = 8;
  localparam int CNT_W_DEF    = 16;
  // Wide enough for the negated, de-scaled product sum before it is clipped.
  localparam int SAT_IN_W     = W_DEF + 4;

  typedef enum logic [1:0] {IDLE, MUL, SUM, UPD} state_t;

  typedef struct packed {
    logic                    ovf;
    logic signed [W_DEF-1:0] val;
  } sat_res_t;

  localparam logic signed [SAT_IN_W-1:0] SAT_MAX = SAT_IN_W'(2 ** (W_DEF - 1) - 1);
  localparam logic signed [SAT_IN_W-1:0] SAT_MIN = ~SAT_MAX;

  function automatic sat_res_t sat_to_w(input logic signed [SAT_IN_W-1:0] val);
    sat_res_t r;
    r.ovf = 1'b0;
    r.val = val[W_DEF-1:0];
    if (val > SAT_MAX) begin
      r.ovf = 1'b1;
      r.val = SAT_MAX[W_DEF-1:0];
    end else if (val < SAT_MIN) begin
      r.ovf = 1'b1;
      r.val = SAT_MIN[W_DEF-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/ode_sat_add.sv
// Signed W-bit adder that clips to the representable range and flags the clip.
module ode_sat_add
  import ode_pkg::*;
(
  input  logic signed [W_DEF-1:0] a,
  input  logic signed [W_DEF-1:0] b,
  output logic signed [W_DEF-1:0] sum,
  output logic                    ovf
);

  logic signed [SAT_IN_W-1:0] wide;
  sat_res_t                   res;

  always_comb begin
    wide = SAT_IN_W'(a) + SAT_IN_W'(b);
    res  = sat_to_w(wide);
  end

  assign sum = res.val;
  assign ovf = res.ovf;

endmodule

// File: rtl/ode_euler_engine.sv
// Damped oscillator x'' = -k*x - b*v integrated by explicit forward Euler,
// one step per four clocks (IDLE -> MUL -> SUM -> UPD) while clk_en is high.
module ode_euler_engine
  import ode_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int FRAC     = FRAC_DEF,
  parameter int DT_SHIFT = DT_SHIFT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sw_rst,
  input  logic                clk_en,
  input  logic signed [W-1:0] k_coef,
  input  logic signed [W-1:0] b_coef,
  input  logic signed [W-1:0] v_init,
  input  logic signed [W-1:0] x_init,
  output logic signed [W-1:0] x_out,
  output logic signed [W-1:0] v_out,
  output logic                sample_valid,
  output logic [CNT_W-1:0]    step_count,
  output logic                sat_flag,
  output logic                busy
);

  state_t                  state_reg;
  logic signed [W-1:0]     x_reg, v_reg, a_reg;
  logic signed [2*W-1:0]   px_reg, pv_reg;
  logic                    sample_valid_reg;
  logic [CNT_W-1:0]        step_count_reg;
  logic                    sat_flag_reg;

  logic signed [2*W-1:0]   px_next, pv_next;
  logic signed [2*W:0]     psum;
  logic signed [SAT_IN_W-1:0] acc_neg;
  sat_res_t                a_res;
  logic signed [W-1:0]     a_shift, v_shift, v_upd, x_upd;
  logic                    v_ovf, x_ovf;

  // Full-width signed products; operands are sign-extended so the low 2W bits are exact.
  assign px_next = (2*W)'(k_coef) * (2*W)'(x_reg);
  assign pv_next = (2*W)'(b_coef) * (2*W)'(v_reg);

  // The shifted sum fits in W+3 bits, so its negation cannot wrap in SAT_IN_W bits.
  assign psum    = (2*W+1)'(px_reg) + (2*W+1)'(pv_reg);
  assign acc_neg = -(SAT_IN_W'(psum >>> FRAC));
  assign a_res   = sat_to_w(acc_neg);

  assign a_shift = a_reg >>> DT_SHIFT;
  assign v_shift = v_reg >>> DT_SHIFT;

  ode_sat_add u_v_add (.a(v_reg), .b(a_shift), .sum(v_upd), .ovf(v_ovf));
  ode_sat_add u_x_add (.a(x_reg), .b(v_shift), .sum(x_upd), .ovf(x_ovf));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      x_reg            <= '0;
      v_reg            <= '0;
      a_reg            <= '0;
      px_reg           <= '0;
      pv_reg           <= '0;
      sample_valid_reg <= 1'b0;
      step_count_reg   <= '0;
      sat_flag_reg     <= 1'b0;
    end else begin
      sample_valid_reg <= 1'b0;
      if (sw_rst) begin
        // Load wins over any step in flight; partial results are simply dropped.
        state_reg      <= IDLE;
        x_reg          <= x_init;
        v_reg          <= v_init;
        step_count_reg <= '0;
        sat_flag_reg   <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: if (clk_en) state_reg <= MUL;
          MUL: begin
            px_reg    <= px_next;
            pv_reg    <= pv_next;
            state_reg <= SUM;
          end
          SUM: begin
            a_reg <= a_res.val;
            if (a_res.ovf) sat_flag_reg <= 1'b1;
            state_reg <= UPD;
          end
          UPD: begin
            v_reg            <= v_upd;
            x_reg            <= x_upd;
            if (v_ovf || x_ovf) sat_flag_reg <= 1'b1;
            sample_valid_reg <= 1'b1;
            step_count_reg   <= step_count_reg + CNT_W'(1);
            state_reg        <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign x_out        = x_reg;
  assign v_out        = v_reg;
  assign sample_valid = sample_valid_reg;
  assign step_count   = step_count_reg;
  assign sat_flag     = sat_flag_reg;
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_ode_euler_engine.sv
// Directed bench for ode_euler_engine with hand-computed Euler step results.
module tb_ode_euler_engine;

  logic               clk = 1'b0;
  logic               reset;
  logic               sw_rst;
  logic               clk_en;
  logic signed [17:0] k_coef, b_coef, v_init, x_init;
  logic signed [17:0] x_out, v_out;
  logic               sample_valid;
  logic [15:0]        step_count;
  logic               sat_flag;
  logic               busy;

  int tests = 0;
  int fails = 0;

  ode_euler_engine dut (
    .clk(clk), .reset(reset), .sw_rst(sw_rst), .clk_en(clk_en),
    .k_coef(k_coef), .b_coef(b_coef), .v_init(v_init), .x_init(x_init),
    .x_out(x_out), .v_out(v_out), .sample_valid(sample_valid),
    .step_count(step_count), .sat_flag(sat_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int k, input int b, input int xi, input int vi, input string tag);
    clk_en = 1'b0;
    k_coef = 18'(k); b_coef = 18'(b); x_init = 18'(xi); v_init = 18'(vi);
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    check({tag, "_x"}, x_out, xi);
    check({tag, "_v"}, v_out, vi);
    check({tag, "_cnt"}, step_count, 0);
    check({tag, "_sat"}, sat_flag, 0);
    check({tag, "_busy"}, busy, 0);
    $display("[TB] load %s x=%0d v=%0d", tag, x_out, v_out);
  endtask

  // Assumes the FSM idles now with clk_en high; the sample must appear on the 4th edge.
  task automatic step_expect(input int xe, input int ve, input int cnt, input string tag);
    int early = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (sample_valid) early++;
    end
    check({tag, "_early_valid"}, early, 0);
    tick();
    check({tag, "_valid"}, sample_valid, 1);
    check({tag, "_x"}, x_out, xe);
    check({tag, "_v"}, v_out, ve);
    check({tag, "_cnt"}, step_count, cnt);
    check({tag, "_busy"}, busy, 0);
    $display("[TB] step %s x=%0d v=%0d cnt=%0d", tag, x_out, v_out, step_count);
  endtask

  initial begin
    int nvalid, at;
    reset = 1'b1; sw_rst = 1'b0; clk_en = 1'b0;
    k_coef = '0; b_coef = '0; v_init = '0; x_init = '0;
    #2;
    check("rst_x", x_out, 0);
    check("rst_v", v_out, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_cnt", step_count, 0);
    check("rst_sat", sat_flag, 0);
    check("rst_busy", busy, 0);
    #10 reset = 1'b0;
    tick();

    // Undamped oscillator
    load(65536, 0, 65536, 0, "undamped_load");
    clk_en = 1'b1;
    step_expect(65536, -256, 1, "undamped1");
    step_expect(65535, -512, 2, "undamped2");

    // Damping only
    load(0, 65536, 0, 65536, "damp_load");
    clk_en = 1'b1;
    step_expect(256, 65280, 1, "damp1");
    step_expect(511, 65025, 2, "damp2");

    // Saturation and sticky flag
    load(0, 0, 131071, 131071, "sat_load");
    clk_en = 1'b1;
    step_expect(131071, 131071, 1, "sat1");
    check("sat1_flag", sat_flag, 1);
    step_expect(131071, 131071, 2, "sat2");
    check("sat2_flag", sat_flag, 1);
    load(0, 0, 5, 7, "sat_clear");

    // Soft reset during SUM
    load(65536, 0, 65536, 0, "mid_load");
    clk_en = 1'b1;
    tick();
    tick();
    check("mid_busy_in_sum", busy, 1);
    sw_rst = 1'b1; x_init = 18'sd1000; v_init = -18'sd2000; clk_en = 1'b0;
    tick();
    sw_rst = 1'b0;
    check("mid_valid", sample_valid, 0);
    check("mid_x", x_out, 1000);
    check("mid_v", v_out, -2000);
    check("mid_cnt", step_count, 0);
    check("mid_busy", busy, 0);
    nvalid = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (sample_valid) nvalid++;
    end
    check("mid_no_sample", nvalid, 0);
    $display("[TB] mid-step sw_rst x=%0d v=%0d", x_out, v_out);

    // Single-cycle enable pulse: x=1000 v=-2000 k=1.0 -> a=-1000
    clk_en = 1'b1;
    tick();
    clk_en = 1'b0;
    nvalid = 0; at = 0;
    for (int i = 1; i <= 8; i++) begin
      if (sample_valid) begin nvalid++; at = i; end
      tick();
    end
    check("pulse_count", nvalid, 1);
    check("pulse_at", at, 4);
    check("pulse_x", x_out, 992);
    check("pulse_v", v_out, -2004);
    check("pulse_cnt", step_count, 1);
    $display("[TB] pulse x=%0d v=%0d", x_out, v_out);

    // Drop clk_en during MUL
    clk_en = 1'b1;
    tick();
    check("drop_busy_mul", busy, 1);
    clk_en = 1'b0;
    nvalid = 0; at = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (sample_valid) begin nvalid++; at = i; end
    end
    check("drop_count", nvalid, 1);
    check("drop_at", at, 3);
    check("drop_x", x_out, 984);
    check("drop_v", v_out, -2008);
    check("drop_cnt", step_count, 2);
    $display("[TB] drop x=%0d v=%0d", x_out, v_out);

    // Async reset mid-run, not aligned to the clock
    clk_en = 1'b1;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    check("arst_x", x_out, 0);
    check("arst_v", v_out, 0);
    check("arst_valid", sample_valid, 0);
    check("arst_cnt", step_count, 0);
    check("arst_sat", sat_flag, 0);
    check("arst_busy", busy, 0);
    #2 reset = 1'b0;
    step_expect(0, 0, 1, "arst_step1");
    step_expect(0, 0, 2, "arst_step2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
